wave_analyzer: RTL and testbench

- Receive-side counterpart to the DDS wave generator. Consumes the 16-bit summed waveform sample stream, for example from the ADC capture path or a loopback of the generator output.
- Detects rising midpoint crossings with hysteresis. For each full cycle it measures the period (in samples), the max, the min and the peak-to-peak amplitude.
- Each per-cycle result is presented on a valid/ready output port to the control/readout logic.

---
 rtl/wave_analyzer.sv | 185 ++++++++++++++++++
 tb/tb_wave_analyzer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/wave_analyzer.sv
// Rising-crossing wave analyzer: per-cycle period, max, min and peak-to-peak with a valid/ready result port.
// Optional: define WAVE_ANALYZER_PERIOD_AVG_EN to report the mean of the last four periods.
module wave_analyzer #(
  parameter logic [15:0] MID   = 16'h8000,
  parameter logic [15:0] HYST  = 16'h0100,
  parameter int          CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  input  logic [15:0]      s_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_period,
  output logic [15:0]      res_max,
  output logic [15:0]      res_min,
  output logic [15:0]      res_pp,
  output logic             no_signal,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam logic [15:0]      LO_TH    = MID - HYST;
  localparam logic [15:0]      HI_TH    = MID + HYST;
  // Last value cnt may hold: the next increment would reach 2^CNT_W-1.
  localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {WAIT_LOW, WAIT_HIGH} state_e;

  state_e           state_q, state_d;
  logic             first_done_q, first_done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      max_q, max_d, min_q, min_d;
  logic             res_valid_q, res_valid_d;
  logic [CNT_W-1:0] res_period_q, res_period_d;
  logic [15:0]      res_max_q, res_max_d, res_min_q, res_min_d, res_pp_q, res_pp_d;
  logic             no_signal_q, no_signal_d;
  logic             overrun_q, overrun_d;

  logic             crossing, load, emit, drop;
  logic [CNT_W-1:0] period_val;

`ifdef WAVE_ANALYZER_PERIOD_AVG_EN
  localparam int SUM_W = CNT_W + 2;
  logic [CNT_W-1:0] hist_q [3];
  logic [CNT_W-1:0] hist_d [3];
  logic [1:0]       hist_n_q, hist_n_d;
  logic [SUM_W-1:0] sum;
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    first_done_d = first_done_q;
    cnt_d        = cnt_q;
    max_d        = max_q;
    min_d        = min_q;
    res_valid_d  = res_valid_q;
    res_period_d = res_period_q;
    res_max_d    = res_max_q;
    res_min_d    = res_min_q;
    res_pp_d     = res_pp_q;
    no_signal_d  = no_signal_q;
    crossing     = 1'b0;
    drop         = 1'b0;
`ifdef WAVE_ANALYZER_PERIOD_AVG_EN
    hist_d       = hist_q;
    hist_n_d     = hist_n_q;
    sum          = SUM_W'(cnt_q) + SUM_W'(hist_q[0]) + SUM_W'(hist_q[1]) + SUM_W'(hist_q[2]);
    period_val   = sum[SUM_W-1:2];
    emit         = (hist_n_q == 2'd3);
`else
    period_val   = cnt_q;
    emit         = 1'b1;
`endif

    if (s_valid) begin
      if (state_q == WAIT_LOW) begin
        if (s_data < LO_TH) state_d = WAIT_HIGH;
      end else if (s_data >= HI_TH) begin
        crossing = 1'b1;
        state_d  = WAIT_LOW;
      end

      if (crossing) begin
        if (first_done_q) begin
          no_signal_d = 1'b0;
`ifdef WAVE_ANALYZER_PERIOD_AVG_EN
          hist_d[2] = hist_q[1];
          hist_d[1] = hist_q[0];
          hist_d[0] = cnt_q;
          if (hist_n_q != 2'd3) hist_n_d = hist_n_q + 2'd1;
`endif
        end
        first_done_d = 1'b1;
        cnt_d        = CNT_ONE;
        max_d        = s_data;
        min_d        = s_data;
      end else if (cnt_q == CNT_LAST) begin
        no_signal_d  = 1'b1;
        first_done_d = 1'b0;
        state_d      = WAIT_LOW;
        cnt_d        = '0;
        max_d        = 16'h0000;
        min_d        = 16'hFFFF;
`ifdef WAVE_ANALYZER_PERIOD_AVG_EN
        hist_n_d     = 2'd0;
        for (int i = 0; i < 3; i++) hist_d[i] = '0;
`endif
      end else begin
        cnt_d = cnt_q + CNT_ONE;
        if (s_data > max_q) max_d = s_data;
        if (s_data < min_q) min_d = s_data;
      end
    end

    // A pending result is only replaced when it is being accepted in the same cycle.
    load = crossing && first_done_q && emit;
    if (load) begin
      if (!res_valid_q || res_ready) begin
        res_valid_d  = 1'b1;
        res_period_d = period_val;
        res_max_d    = max_q;
        res_min_d    = min_q;
        res_pp_d     = max_q - min_q;
      end else begin
        drop = 1'b1;
      end
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end

    overrun_d = drop ? 1'b1 : (ovr_clr ? 1'b0 : overrun_q);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_LOW;
      first_done_q <= 1'b0;
      cnt_q        <= '0;
      max_q        <= 16'h0000;
      min_q        <= 16'hFFFF;
      res_valid_q  <= 1'b0;
      res_period_q <= '0;
      res_max_q    <= '0;
      res_min_q    <= '0;
      res_pp_q     <= '0;
      no_signal_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef WAVE_ANALYZER_PERIOD_AVG_EN
      // NOTE: the history is only three words, so it is reset like ordinary flops.
      hist_n_q     <= 2'd0;
      for (int i = 0; i < 3; i++) hist_q[i] <= '0;
`endif
    end else begin
      state_q      <= state_d;
      first_done_q <= first_done_d;
      cnt_q        <= cnt_d;
      max_q        <= max_d;
      min_q        <= min_d;
      res_valid_q  <= res_valid_d;
      res_period_q <= res_period_d;
      res_max_q    <= res_max_d;
      res_min_q    <= res_min_d;
      res_pp_q     <= res_pp_d;
      no_signal_q  <= no_signal_d;
      overrun_q    <= overrun_d;
`ifdef WAVE_ANALYZER_PERIOD_AVG_EN
      hist_n_q     <= hist_n_d;
      hist_q       <= hist_d;
`endif
    end
  end

  assign res_valid  = res_valid_q;
  assign res_period = res_period_q;
  assign res_max    = res_max_q;
  assign res_min    = res_min_q;
  assign res_pp     = res_pp_q;
  assign no_signal  = no_signal_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_wave_analyzer.sv
// Directed self-checking bench for wave_analyzer (CNT_W=8 so the timeout is reachable).
// With WAVE_ANALYZER_PERIOD_AVG_EN defined it runs the period-averaging scenario instead.
module tb_wave_analyzer;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             s_valid;
  logic [15:0]      s_data;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_period;
  logic [15:0]      res_max, res_min, res_pp;
  logic             no_signal, overrun, ovr_clr;

  wave_analyzer #(.MID(16'h8000), .HYST(16'h0100), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_period(res_period),
    .res_max(res_max), .res_min(res_min), .res_pp(res_pp),
    .no_signal(no_signal), .overrun(overrun), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               idx;
    logic [CNT_W-1:0] period;
    logic [15:0]      mx, mn, pp;
  } res_t;

  res_t log_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   idx = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drives one cycle; idx numbers consumed samples, and any result shown while ready is high gets logged.
  task automatic step(input logic v, input logic [15:0] d);
    s_valid = v;
    s_data  = d;
    @(posedge clk);
    #1;
    if (v) idx++;
    if (res_valid && res_ready)
      log_q.push_back('{idx, res_period, res_max, res_min, res_pp});
  endtask

  task automatic wave(input logic [15:0] hi, input logic [15:0] lo, input int nh, input int nl, input bit gap);
    for (int i = 0; i < nh; i++) begin
      step(1'b1, hi);
      if (gap) step(1'b0, 16'h0000);
    end
    for (int i = 0; i < nl; i++) begin
      step(1'b1, lo);
      if (gap) step(1'b0, 16'h0000);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    s_valid   = 1'b0;
    s_data    = 16'h0000;
    res_ready = 1'b1;
    ovr_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idx   = 0;
    log_q.delete();
  endtask

  task automatic check_res(input string tag, input int k, input int exp_idx, input int period,
                           input logic [15:0] mx, input logic [15:0] mn);
    if (k < log_q.size()) begin
      check({tag, " idx"},    log_q[k].idx,    exp_idx);
      check({tag, " period"}, log_q[k].period, period);
      check({tag, " max"},    log_q[k].mx,     mx);
      check({tag, " min"},    log_q[k].mn,     mn);
      check({tag, " pp"},     log_q[k].pp,     mx - mn);
    end else begin
      check({tag, " present"}, 0, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0; res_ready = 1'b1; ovr_clr = 1'b0;
    #3;
    check("reset res_valid",  res_valid,  0);
    check("reset res_period", res_period, 0);
    check("reset res_max",    res_max,    0);
    check("reset res_min",    res_min,    0);
    check("reset res_pp",     res_pp,     0);
    check("reset no_signal",  no_signal,  0);
    check("reset overrun",    overrun,    0);

`ifdef WAVE_ANALYZER_PERIOD_AVG_EN
    // Periods 16,16,20,20 -> mean 18; then 24 -> mean 20.
    do_reset();
    repeat (3) wave(16'h9000, 16'h7000, 8, 8, 1'b0);
    wave(16'h9000, 16'h7000, 10, 10, 1'b0);
    wave(16'h9000, 16'h7000, 10, 10, 1'b0);
    wave(16'h9000, 16'h7000, 12, 12, 1'b0);
    step(1'b1, 16'h9000);
    check("avg count", log_q.size(), 2);
    check_res("avg first",  0, 89,  18, 16'h9000, 16'h7000);
    check_res("avg second", 1, 113, 20, 16'h9000, 16'h7000);
`else
    // Basic measurement: crossings at samples 17, 33, 49, 65.
    do_reset();
    repeat (5) wave(16'h9000, 16'h7000, 8, 8, 1'b0);
    check("basic count", log_q.size(), 3);
    check_res("basic r0", 0, 33, 16, 16'h9000, 16'h7000);
    check_res("basic r1", 1, 49, 16, 16'h9000, 16'h7000);
    check_res("basic r2", 2, 65, 16, 16'h9000, 16'h7000);

    // Gapped valid: idle cycles carry 0x0000, which must be ignored.
    do_reset();
    repeat (5) wave(16'h9000, 16'h7000, 8, 8, 1'b1);
    check("gap count", log_q.size(), 3);
    check_res("gap r0", 0, 33, 16, 16'h9000, 16'h7000);
    check_res("gap r2", 2, 65, 16, 16'h9000, 16'h7000);

    // Hysteresis: in-band tone never crosses; timeout on the 255th sample.
    do_reset();
    for (int i = 0; i < 254; i++) step(1'b1, ((i % 8) < 4) ? 16'h7F80 : 16'h8080);
    check("hyst no_signal before", no_signal, 0);
    check("hyst no results", log_q.size(), 0);
    step(1'b1, 16'h7F80);
    check("hyst no_signal at 255", no_signal, 1);
    idx = 0;
    repeat (3) wave(16'h9000, 16'h7000, 8, 8, 1'b0);
    check("post-timeout count", log_q.size(), 1);
    check_res("post-timeout r0", 0, 33, 16, 16'h9000, 16'h7000);
    check("post-timeout no_signal", no_signal, 0);

    // Backpressure: hold, drop with overrun, clear, then load-while-accept.
    do_reset();
    res_ready = 1'b0;
    repeat (2) wave(16'h9000, 16'h7000, 8, 8, 1'b0);
    step(1'b1, 16'hA000);
    check("bp load valid",  res_valid,  1);
    check("bp load period", res_period, 16);
    check("bp load max",    res_max,    16'h9000);
    for (int i = 0; i < 7; i++) step(1'b1, 16'hA000);
    for (int i = 0; i < 8; i++) step(1'b1, 16'h6000);
    check("bp hold max",     res_max, 16'h9000);
    check("bp hold overrun", overrun, 0);
    step(1'b1, 16'h9000);
    check("bp drop overrun", overrun,    1);
    check("bp drop valid",   res_valid,  1);
    check("bp drop max",     res_max,    16'h9000);
    check("bp drop min",     res_min,    16'h7000);
    check("bp drop pp",      res_pp,     16'h2000);
    check("bp drop period",  res_period, 16);
    wave(16'h9000, 16'h7000, 3, 4, 1'b0);
    ovr_clr = 1'b1;
    step(1'b0, 16'h0000);
    ovr_clr = 1'b0;
    check("bp ovr_clr overrun", overrun,   0);
    check("bp ovr_clr valid",   res_valid, 1);
    res_ready = 1'b1;
    step(1'b0, 16'h0000);
    res_ready = 1'b0;
    check("bp accept valid", res_valid, 0);
    step(1'b1, 16'hB000);
    check("bp r2 valid",  res_valid,  1);
    check("bp r2 period", res_period, 8);
    check("bp r2 max",    res_max,    16'h9000);
    for (int i = 0; i < 7; i++) step(1'b1, 16'hB000);
    for (int i = 0; i < 8; i++) step(1'b1, 16'h5000);
    res_ready = 1'b1;
    step(1'b1, 16'h9000);
    check("bp r3 overrun", overrun,    0);
    check("bp r3 valid",   res_valid,  1);
    check("bp r3 period",  res_period, 16);
    check("bp r3 max",     res_max,    16'hB000);
    check("bp r3 min",     res_min,    16'h5000);
    check("bp r3 pp",      res_pp,     16'h6000);

    // Reset mid-operation: outputs clear asynchronously, then two crossings are needed again.
    do_reset();
    res_ready = 1'b0;
    repeat (2) wave(16'h9000, 16'h7000, 8, 8, 1'b0);
    step(1'b1, 16'h9000);
    check("mid pre valid", res_valid, 1);
    repeat (3) step(1'b1, 16'h9000);
    #2;
    reset = 1'b1;
    #1;
    check("mid async valid",  res_valid,  0);
    check("mid async period", res_period, 0);
    check("mid async max",    res_max,    0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    idx       = 0;
    res_ready = 1'b1;
    log_q.delete();
    repeat (2) wave(16'h9000, 16'h7000, 8, 8, 1'b0);
    check("mid after 2 waves", log_q.size(), 0);
    wave(16'h9000, 16'h7000, 8, 8, 1'b0);
    check("mid after 3 waves", log_q.size(), 1);
    check_res("mid r0", 0, 33, 16, 16'h9000, 16'h7000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
